// File: rtl/bridge_arbiter_if.sv
// -----------------------------------------------------------------------------
// bridge_arbiter_if
// Groups every signal of the arbiter except clk/rst: the requester side
// (hold-until-response handshake) and the shared DRAM bridge channel.
//   slave  : the arbiter's view (samples requests and bridge completions,
//            drives responses and bridge commands)
//   master : the environment's view (requesters plus the bridge)
// Requester fields are flattened: requester i lives at [i*W +: W].
// -----------------------------------------------------------------------------
interface bridge_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64
);
    // requester side
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_r_wb;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic [1:0]                grant_id;
    logic                      busy;
    // bridge side
    logic [ADDR_W-1:0]         C_addr;
    logic [DATA_W-1:0]         C_data_w;
    logic                      C_in_valid;
    logic                      C_r_wb;
    logic                      C_out_valid;
    logic [DATA_W-1:0]         C_data_r;

    modport slave (
        input  req_valid, req_r_wb, req_addr, req_wdata, req_lock,
        input  C_out_valid, C_data_r,
        output rsp_valid, rsp_data, rsp_err, grant_id, busy,
        output C_addr, C_data_w, C_in_valid, C_r_wb
    );

    modport master (
        output req_valid, req_r_wb, req_addr, req_wdata, req_lock,
        output C_out_valid, C_data_r,
        input  rsp_valid, rsp_data, rsp_err, grant_id, busy,
        input  C_addr, C_data_w, C_in_valid, C_r_wb
    );
endinterface

// File: rtl/bridge_arbiter.sv
// -----------------------------------------------------------------------------
// bridge_arbiter
// Shares one DRAM bridge channel between NUM_REQ (2..4) requesters. One
// transaction at a time, round-robin, single outstanding bridge command.
// A watchdog turns a missing bridge completion into an error response.
//
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset
//   bus   : bridge_arbiter_if.slave
//           req_valid/req_r_wb/req_addr/req_wdata/req_lock  (requesters in)
//           rsp_valid/rsp_data/rsp_err/grant_id/busy        (requesters out)
//           C_addr/C_data_w/C_in_valid/C_r_wb               (bridge out)
//           C_out_valid/C_data_r                            (bridge in)
//
// Optional feature macro: ARB_LOCK_EN
//   defined   : req_lock[grant_id] high at RESP (no timeout) keeps ownership
//               with the served requester for following transactions.
//   undefined : req_lock is ignored, pure round-robin.
// -----------------------------------------------------------------------------
module bridge_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    bridge_arbiter_if.slave  bus
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rwb_q, rwb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [TW-1:0]     timer_q, timer_d;

    // Requester fields widened to a fixed 4 slots so a 2-bit id indexes
    // them exactly whatever NUM_REQ is; unused slots read as idle.
    logic [3:0]        valid4, rwb4;
    logic [ADDR_W-1:0] addr_a  [4];
    logic [DATA_W-1:0] wdata_a [4];

    for (genvar i = 0; i < 4; i++) begin : g_slot
        if (i < NUM_REQ) begin : g_on
            assign valid4[i]  = bus.req_valid[i];
            assign rwb4[i]    = bus.req_r_wb[i];
            assign addr_a[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
            assign wdata_a[i] = bus.req_wdata[i*DATA_W +: DATA_W];
        end else begin : g_off
            assign valid4[i]  = 1'b0;
            assign rwb4[i]    = 1'b0;
            assign addr_a[i]  = '0;
            assign wdata_a[i] = '0;
        end
    end

    // Round-robin scan: first requesting slot after the last served one.
    logic       rr_found;
    logic [1:0] rr_id, scan_idx;
    always_comb begin
        rr_found = 1'b0;
        rr_id    = ptr_q;
        scan_idx = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = 2'((int'(ptr_q) + k) % NUM_REQ);
            if (!rr_found && valid4[scan_idx]) begin
                rr_found = 1'b1;
                rr_id    = scan_idx;
            end
        end
    end

    logic       win_found;
    logic [1:0] win_id;

`ifdef ARB_LOCK_EN
    logic       locked_q;
    logic [1:0] owner_q;
    logic [3:0] lock4;

    for (genvar i = 0; i < 4; i++) begin : g_lock
        if (i < NUM_REQ) begin : g_on
            assign lock4[i] = bus.req_lock[i];
        end else begin : g_off
            assign lock4[i] = 1'b0;
        end
    end

    // While locked only the owner may win; everybody else waits.
    always_comb begin
        win_found = rr_found;
        win_id    = rr_id;
        if (locked_q) begin
            win_found = valid4[owner_q];
            win_id    = owner_q;
        end
    end

    // A timed-out transaction always drops the lock so a dead bridge
    // cannot starve the other requesters forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q <= 1'b0;
            owner_q  <= '0;
        end else if (state_q == S_RESP) begin
            if (!err_q && lock4[grant_q]) begin
                locked_q <= 1'b1;
                owner_q  <= grant_q;
            end else begin
                locked_q <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        win_found = rr_found;
        win_id    = rr_id;
    end
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rwb_d   = rwb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = win_id;
                    addr_d  = addr_a[win_id];
                    rwb_d   = rwb4[win_id];
                    wdata_d = rwb4[win_id] ? '0 : wdata_a[win_id];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.C_out_valid) begin
                    rdata_d = rwb_q ? bus.C_data_r : '0;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // TIMEOUT cycles spent in WAIT without a completion
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                ptr_d   = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'(NUM_REQ - 1);
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rwb_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rwb_q   <= rwb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.C_in_valid = (state_q == S_ISSUE);
    assign bus.rsp_valid  = (state_q == S_RESP) ? NUM_REQ'(4'b0001 << grant_q) : '0;
    assign bus.rsp_data   = rdata_q;
    assign bus.rsp_err    = err_q;
    assign bus.grant_id   = grant_q;
    assign bus.C_addr     = addr_q;
    assign bus.C_data_w   = wdata_q;
    assign bus.C_r_wb     = rwb_q;

endmodule

// File: tb/tb_bridge_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bridge_arbiter
// Self-checking bench for bridge_arbiter. Requesters and the bridge are
// modelled by tasks; expected winners come from a pending-request table and
// the round-robin rule, expected data/latency from the transaction fields.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bridge_arbiter;
    localparam int NR = 2;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bridge_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    bridge_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int fails = 0;

    // reference model: pending requests and last served requester
    bit            pend  [NR];
    logic          rwb_m [NR];
    logic [AW-1:0] adr_m [NR];
    logic [DW-1:0] wd_m  [NR];
    int            last_srv;

    function automatic int pick(input int last);
        for (int k = 1; k <= NR; k++) begin
            if (pend[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic lk);
        bus.req_r_wb[i]          = rw;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
        bus.req_lock[i]          = lk;
        bus.req_valid[i]         = 1'b1;
        pend[i] = 1'b1; rwb_m[i] = rw; adr_m[i] = a; wd_m[i] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0; bus.req_lock = '0; bus.C_out_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        last_srv = NR - 1;
    endtask

    // Plays the bridge for one transaction and reports what was seen.
    // lat = cycles from the C_in_valid cycle to the C_out_valid cycle.
    task automatic run_txn(input int lat, input bit answer, input logic [DW-1:0] rdata,
                           output bit done, output int n_issue,
                           output logic [AW-1:0] a, output logic rw, output logic [DW-1:0] wd,
                           output int rsp_id, output logic [DW-1:0] rd, output logic err,
                           output int delay);
        int cyc, t_iss, nset;
        bit issued;
        done = 0; n_issue = 0; issued = 0; t_iss = 0; cyc = 0;
        a = '0; rw = 1'b0; wd = '0; rsp_id = -1; rd = '0; err = 1'b0; delay = 0;
        while (!done && cyc < TO + 50) begin
            step(); cyc++;
            bus.C_out_valid = 1'b0;
            if (bus.C_in_valid) begin
                n_issue++;
                if (!issued) begin
                    issued = 1; t_iss = cyc;
                    a = bus.C_addr; rw = bus.C_r_wb; wd = bus.C_data_w;
                end
            end
            if (issued && answer && cyc == t_iss + lat) begin
                bus.C_out_valid = 1'b1;
                bus.C_data_r    = rdata;
            end
            if (bus.rsp_valid != '0) begin
                done = 1; delay = cyc - t_iss; rd = bus.rsp_data; err = bus.rsp_err;
                nset = 0;
                for (int i = 0; i < NR; i++) begin
                    if (bus.rsp_valid[i]) begin
                        nset++; rsp_id = i; bus.req_valid[i] = 1'b0;
                    end
                end
                if (nset != 1) rsp_id = -2;
            end
        end
        bus.C_out_valid = 1'b0;
    endtask

    bit done; int n_iss, rid, dly;
    logic [AW-1:0] o_a; logic o_rw, o_err; logic [DW-1:0] o_wd, o_rd;

    task automatic test_reset();
        do_reset();
        total++; if ({bus.rsp_valid, bus.rsp_err, bus.busy, bus.C_in_valid, bus.C_r_wb, bus.grant_id} !== '0) begin
            fails++; $display("FAIL reset_ctl: got %b want 0", {bus.rsp_valid, bus.rsp_err, bus.busy, bus.C_in_valid, bus.C_r_wb, bus.grant_id}); end
        total++; if (bus.rsp_data !== '0) begin fails++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
        total++; if (bus.C_addr !== '0) begin fails++; $display("FAIL reset_addr: got %h want 0", bus.C_addr); end
        total++; if (bus.C_data_w !== '0) begin fails++; $display("FAIL reset_wdata: got %h want 0", bus.C_data_w); end
    endtask

    task automatic test_single_read();
        set_req(0, 1'b1, 8'h05, 64'hFFFF_0000_FFFF_0000, 1'b0);
        run_txn(2, 1, 64'hA5A5_0000_1234_5678, done, n_iss, o_a, o_rw, o_wd, rid, o_rd, o_err, dly);
        pend[0] = 0; last_srv = 0;
        total++; if (done !== 1'b1) begin fails++; $display("FAIL rd_done: got %0d want 1", done); end
        total++; if (n_iss !== 1) begin fails++; $display("FAIL rd_issue: got %0d want 1", n_iss); end
        total++; if (o_rw !== 1'b1 || o_a !== 8'h05) begin fails++; $display("FAIL rd_cmd: got rw=%b a=%h want 1/05", o_rw, o_a); end
        total++; if (o_wd !== '0) begin fails++; $display("FAIL rd_wdata: got %h want 0", o_wd); end
        total++; if (rid !== 0) begin fails++; $display("FAIL rd_id: got %0d want 0", rid); end
        total++; if (o_rd !== 64'hA5A5_0000_1234_5678 || o_err !== 1'b0) begin
            fails++; $display("FAIL rd_data: got %h err=%b want a5a5000012345678/0", o_rd, o_err); end
        total++; if (dly !== 3) begin fails++; $display("FAIL rd_latency: got %0d want 3", dly); end
    endtask

    task automatic test_write();
        set_req(1, 1'b0, 8'hFF, 64'h1, 1'b0);
        run_txn(3, 1, 64'hDEAD_BEEF_DEAD_BEEF, done, n_iss, o_a, o_rw, o_wd, rid, o_rd, o_err, dly);
        pend[1] = 0; last_srv = 1;
        total++; if (o_rw !== 1'b0 || o_a !== 8'hFF || o_wd !== 64'h1) begin
            fails++; $display("FAIL wr_cmd: got rw=%b a=%h d=%h want 0/ff/1", o_rw, o_a, o_wd); end
        total++; if (rid !== 1) begin fails++; $display("FAIL wr_id: got %0d want 1", rid); end
        total++; if (o_rd !== '0 || o_err !== 1'b0) begin fails++; $display("FAIL wr_rsp: got %h err=%b want 0/0", o_rd, o_err); end
    endtask

    task automatic test_contention();
        int exp;
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(8'h10 + i), '0, 1'b0);
        for (int it = 0; it < 5; it++) begin
            exp = pick(last_srv);
            run_txn(2, 1, DW'(64'h100 + it), done, n_iss, o_a, o_rw, o_wd, rid, o_rd, o_err, dly);
            total++; if (rid !== exp || n_iss !== 1) begin
                fails++; $display("FAIL cont_grant%0d: got id=%0d issues=%0d want id=%0d issues=1", it, rid, n_iss, exp); end
            total++; if (o_a !== adr_m[exp]) begin fails++; $display("FAIL cont_addr%0d: got %h want %h", it, o_a, adr_m[exp]); end
            pend[exp] = 0; last_srv = exp;
            if (it < 3) set_req(exp, 1'b1, AW'(8'h10 + exp), '0, 1'b0);
        end
    endtask

    task automatic test_timeout();
        bit quiet;
        set_req(0, 1'b1, 8'h44, '0, 1'b0);
        run_txn(0, 0, '0, done, n_iss, o_a, o_rw, o_wd, rid, o_rd, o_err, dly);
        pend[0] = 0; last_srv = 0;
        total++; if (done !== 1'b1 || rid !== 0) begin fails++; $display("FAIL to_done: got done=%0d id=%0d want 1/0", done, rid); end
        total++; if (o_err !== 1'b1 || o_rd !== '0) begin fails++; $display("FAIL to_rsp: got err=%b d=%h want 1/0", o_err, o_rd); end
        total++; if (dly !== TO + 1) begin fails++; $display("FAIL to_latency: got %0d want %0d", dly, TO + 1); end
        // late completion arriving while idle must be ignored
        step();
        bus.C_out_valid = 1'b1; bus.C_data_r = {$urandom, $urandom};
        step();
        bus.C_out_valid = 1'b0;
        quiet = 1;
        for (int c = 0; c < 3; c++) begin
            if (bus.rsp_valid != '0 || bus.busy || bus.C_in_valid) quiet = 0;
            step();
        end
        total++; if (quiet !== 1'b1) begin fails++; $display("FAIL to_late_ignored: got activity want idle"); end
        total++; if (bus.rsp_err !== 1'b1) begin fails++; $display("FAIL to_err_hold: got %b want 1", bus.rsp_err); end
        set_req(1, 1'b1, 8'h45, '0, 1'b0);
        run_txn(1, 1, 64'h0123_4567_89AB_CDEF, done, n_iss, o_a, o_rw, o_wd, rid, o_rd, o_err, dly);
        pend[1] = 0; last_srv = 1;
        total++; if (rid !== 1 || o_err !== 1'b0 || o_rd !== 64'h0123_4567_89AB_CDEF) begin
            fails++; $display("FAIL to_recover: got id=%0d err=%b d=%h want 1/0/0123456789abcdef", rid, o_err, o_rd); end
    endtask

    task automatic test_reset_wait();
        int c;
        bit quiet;
        set_req(0, 1'b1, 8'h33, '0, 1'b0);
        c = 0;
        while (!bus.C_in_valid && c < 10) begin step(); c++; end
        total++; if (bus.C_in_valid !== 1'b1) begin fails++; $display("FAIL rw_issue: got %b want 1", bus.C_in_valid); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; bus.req_valid = '0; pend[0] = 0; last_srv = NR - 1;
        total++; if ({bus.rsp_valid, bus.busy, bus.C_in_valid, bus.C_r_wb, bus.grant_id, bus.rsp_err} !== '0) begin
            fails++; $display("FAIL rw_ctl: got %b want 0", {bus.rsp_valid, bus.busy, bus.C_in_valid, bus.C_r_wb, bus.grant_id, bus.rsp_err}); end
        total++; if (bus.C_addr !== '0 || bus.rsp_data !== '0) begin
            fails++; $display("FAIL rw_regs: got a=%h d=%h want 0/0", bus.C_addr, bus.rsp_data); end
        bus.C_out_valid = 1'b1; bus.C_data_r = 64'h5555;
        quiet = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            bus.C_out_valid = 1'b0;
            if (bus.rsp_valid != '0 || bus.busy) quiet = 0;
        end
        total++; if (quiet !== 1'b1) begin fails++; $display("FAIL rw_no_rsp: got activity want idle"); end
        set_req(0, 1'b1, 8'h34, '0, 1'b0);
        run_txn(2, 1, 64'h7777_8888, done, n_iss, o_a, o_rw, o_wd, rid, o_rd, o_err, dly);
        pend[0] = 0; last_srv = 0;
        total++; if (rid !== 0 || o_rd !== 64'h7777_8888 || dly !== 3 || o_a !== 8'h34) begin
            fails++; $display("FAIL rw_after: got id=%0d d=%h lat=%0d a=%h want 0/77778888/3/34", rid, o_rd, dly, o_a); end
    endtask

    task automatic test_random();
        int exp, lat, any;
        logic [DW-1:0] rdat;
        for (int it = 0; it < 40 + NR; it++) begin
            if (it < 40) begin
                for (int i = 0; i < NR; i++)
                    if (!pend[i] && $urandom_range(0, 1) == 1)
                        set_req(i, 1'($urandom), AW'($urandom), {$urandom, $urandom}, 1'b0);
            end
            any = 0;
            for (int i = 0; i < NR; i++) if (pend[i]) any = 1;
            if (it < 40 && any == 0)
                set_req(0, 1'($urandom), AW'($urandom), {$urandom, $urandom}, 1'b0);
            exp = pick(last_srv);
            if (exp < 0) break;
            lat  = $urandom_range(1, 5);
            rdat = {$urandom, $urandom};
            run_txn(lat, 1, rdat, done, n_iss, o_a, o_rw, o_wd, rid, o_rd, o_err, dly);
            total++; if (rid !== exp || n_iss !== 1) begin
                fails++; $display("FAIL rnd_grant%0d: got id=%0d issues=%0d want %0d/1", it, rid, n_iss, exp); end
            total++; if (o_a !== adr_m[exp] || o_rw !== rwb_m[exp] || o_wd !== (rwb_m[exp] ? '0 : wd_m[exp])) begin
                fails++; $display("FAIL rnd_cmd%0d: got a=%h rw=%b d=%h want %h/%b/%h", it, o_a, o_rw, o_wd,
                                  adr_m[exp], rwb_m[exp], rwb_m[exp] ? '0 : wd_m[exp]); end
            total++; if (o_rd !== (rwb_m[exp] ? rdat : '0) || o_err !== 1'b0 || dly !== lat + 1) begin
                fails++; $display("FAIL rnd_rsp%0d: got d=%h err=%b lat=%0d want %h/0/%0d", it, o_rd, o_err, dly,
                                  rwb_m[exp] ? rdat : '0, lat + 1); end
            pend[exp] = 0; last_srv = exp;
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        int seq [4] = '{0, 0, 0, 1};
        do_reset();
        set_req(1, 1'b1, 8'h21, '0, 1'b0);
        set_req(0, 1'b1, 8'h20, '0, 1'b1);
        for (int it = 0; it < 4; it++) begin
            run_txn(2, 1, DW'(it), done, n_iss, o_a, o_rw, o_wd, rid, o_rd, o_err, dly);
            total++; if (rid !== seq[it]) begin fails++; $display("FAIL lock_grant%0d: got %0d want %0d", it, rid, seq[it]); end
            if (rid >= 0) pend[rid] = 0;
            if (it == 0) set_req(0, 1'b1, 8'h20, '0, 1'b1);
            if (it == 1) set_req(0, 1'b1, 8'h20, '0, 1'b0);
        end
        bus.req_lock = '0;
        last_srv = 1;
    endtask
`endif

    initial begin
        bus.req_valid = '0; bus.req_r_wb = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_lock = '0; bus.C_out_valid = 1'b0; bus.C_data_r = '0;
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_timeout();
        test_reset_wait();
        test_random();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
